updown_display_counter: RTL

Parametrised multi-digit up/down counter with built-in count prescaler, synchronous load, wrap flag and time-multiplexed seven-segment drive. It sits directly behind the board clock and replaces the single-digit divider/counter/decoder chain at top level. One instance drives an N-digit common-anode display in decimal (BCD) or hexadecimal mode.

---
 rtl/updown_display_counter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/updown_display_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_display_counter
//  Description : Multi-digit BCD/hex up/down counter with count prescaler,
//                synchronous load, wrap flag and time-multiplexed
//                common-anode seven-segment drive.
//  Ports       : clk, rst           - clock, async active-high reset
//                UP_DOWN, pause     - count direction, freeze prescaler/count
//                load, load_value   - synchronous load strobe and value
//                count_out          - nibble-packed count, digit 0 in [3:0]
//                tick_out, wrap_out - one-cycle step / wrap pulses
//                an_out             - active-low digit enables (one-hot-low)
//                Seven_segment_out  - active-low segments {g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_display_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int BCD      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  UP_DOWN,
    input  logic                  pause,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count_out,
    output logic                  tick_out,
    output logic                  wrap_out,
    output logic [DIGITS-1:0]     an_out,
    output logic [6:0]            Seven_segment_out
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]     SCAN_TOP  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [3:0]        DIG_MAX   = (BCD != 0) ? 4'd9 : 4'd15;
    localparam logic [DIGITS-1:0] AN_RST    = ~(DIGITS'(1));
    localparam logic [6:0]        SEG_ZERO  = 7'b1000000;

    logic [PW-1:0]        presc_q, presc_d;
    logic [4*DIGITS-1:0]  count_q, count_d;
    logic                 tick_q, tick_d;
    logic                 wrap_q, wrap_d;
    logic [SW-1:0]        scan_q, scan_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [6:0]           seg_q, seg_d;

    logic                 step;
    logic                 carry;
    logic [4*DIGITS-1:0]  stepped;
    logic [4*DIGITS-1:0]  loaded;
    logic [3:0]           cur_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0:    seg_decode = 7'b1000000;
            4'h1:    seg_decode = 7'b1111001;
            4'h2:    seg_decode = 7'b0100100;
            4'h3:    seg_decode = 7'b0110000;
            4'h4:    seg_decode = 7'b0011001;
            4'h5:    seg_decode = 7'b0010010;
            4'h6:    seg_decode = 7'b0000010;
            4'h7:    seg_decode = 7'b1111000;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0010000;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b0000011;
            4'hC:    seg_decode = 7'b1000110;
            4'hD:    seg_decode = 7'b0100001;
            4'hE:    seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    // Load has priority over a step, so a step is suppressed while loading.
    assign step = (presc_q == PRESC_TOP) && !pause && !load;

    // Ripple increment/decrement. carry enters digit 0 as the +/-1 and leaves
    // the top digit set only when every digit rolled over, i.e. a wrap.
    always_comb begin
        stepped = count_q;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (UP_DOWN) begin
                    if (count_q[4*i +: 4] == DIG_MAX) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        stepped[4*i +: 4] = DIG_MAX;
                    end else begin
                        stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    // In decimal mode an out-of-range nibble is clamped to 9.
    always_comb begin
        loaded = load_value;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_value[4*i +: 4] > DIG_MAX) begin
                loaded[4*i +: 4] = DIG_MAX;
            end
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (load) begin
            presc_d = '0;
        end else if (!pause) begin
            presc_d = (presc_q == PRESC_TOP) ? '0 : presc_q + PW'(1);
        end

        count_d = count_q;
        if (load) begin
            count_d = loaded;
        end else if (step) begin
            count_d = stepped;
        end

        tick_d = step;
        wrap_d = step && carry;
    end

    // Scan runs independently of pause so the display keeps refreshing.
    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_TOP) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit = count_q[4*i +: 4];
            end
        end

        an_d        = '1;
        an_d[idx_q] = 1'b0;
        seg_d       = seg_decode(cur_digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            an_q    <= AN_RST;
            seg_q   <= SEG_ZERO;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign count_out         = count_q;
    assign tick_out          = tick_q;
    assign wrap_out          = wrap_q;
    assign an_out            = an_q;
    assign Seven_segment_out = seg_q;

endmodule
`default_nettype wire
